task_answer_framer: RTL and testbench

//  Downstream stage of a task output block. Consumes its answer byte stream (ready/data/last/packet size).

---
 rtl/task_answer_framer.sv | 164 ++++++++++++++++
 tb/tb_task_answer_framer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/task_answer_framer.sv
// Frames each upstream answer packet for the host link as SYNC, TASK_ID, LEN_HI, LEN_LO, payload, CKSUM.
// Length/last disagreements are flagged on o_len_err, and any surplus bytes are drained without being transmitted.
module task_answer_framer #(
    parameter logic [7:0] TASK_ID   = 8'd9,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tanswer_ready,
    input  logic [7:0]  i_tdata,
    input  logic        i_tanswer_data_last,
    input  logic [11:0] i_packet_size_in_bytes,
    output logic        o_tmanager_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_len_err,
    output logic [15:0] o_frame_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYNC    = 3'd1;
    localparam logic [2:0] S_ID      = 3'd2;
    localparam logic [2:0] S_LEN_HI  = 3'd3;
    localparam logic [2:0] S_LEN_LO  = 3'd4;
    localparam logic [2:0] S_PAYLOAD = 3'd5;
    localparam logic [2:0] S_CKSUM   = 3'd6;
    localparam logic [2:0] S_DRAIN   = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [11:0] len_q, len_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic        len_err_q, len_err_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        mgr_ready;
    logic [11:0] cnt_inc;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        sum_d         = sum_q;
        len_err_d     = len_err_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        mgr_ready     = 1'b0;
        cnt_inc       = cnt_q + 12'd1;

        case (state_q)
            S_IDLE: begin
                if (i_tanswer_ready) begin
                    len_d     = i_packet_size_in_bytes;
                    cnt_d     = 12'd0;
                    sum_d     = 8'h00;
                    len_err_d = 1'b0;
                    state_d   = S_SYNC;
                end
            end
            S_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (i_tx_ready) state_d = S_ID;
            end
            S_ID: begin
                tx_valid = 1'b1;
                tx_data  = TASK_ID;
                if (i_tx_ready) begin
                    sum_d   = sum_q + tx_data;
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                tx_valid = 1'b1;
                tx_data  = {4'h0, len_q[11:8]};
                if (i_tx_ready) begin
                    sum_d   = sum_q + tx_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                tx_valid = 1'b1;
                tx_data  = len_q[7:0];
                if (i_tx_ready) begin
                    sum_d = sum_q + tx_data;
                    if (len_q != 12'd0) begin
                        state_d = S_PAYLOAD;
                    end else begin
                        state_d   = S_CKSUM;
                        len_err_d = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                // Zero-latency pass-through: each side's handshake is the other's.
                tx_valid  = i_tanswer_ready;
                tx_data   = i_tdata;
                mgr_ready = i_tx_ready;
                if (i_tanswer_ready && i_tx_ready) begin
                    cnt_d = cnt_inc;
                    sum_d = sum_q + i_tdata;
                    if (i_tanswer_data_last) begin
                        state_d = S_CKSUM;
                        if (cnt_inc != len_q) len_err_d = 1'b1;
                    end else if (cnt_inc == len_q) begin
                        state_d   = S_DRAIN;
                        len_err_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                mgr_ready = 1'b1;
                if (i_tanswer_ready && i_tanswer_data_last) state_d = S_CKSUM;
            end
            S_CKSUM: begin
                tx_valid = 1'b1;
                tx_data  = 8'h00 - sum_q;
                if (i_tx_ready) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            len_q         <= 12'd0;
            cnt_q         <= 12'd0;
            sum_q         <= 8'h00;
            len_err_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            len_err_q     <= len_err_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign o_tmanager_ready = mgr_ready;
    assign o_tx_data        = tx_data;
    assign o_tx_valid       = tx_valid;
    assign o_busy           = (state_q != S_IDLE);
    assign o_frame_done     = frame_done_q;
    assign o_len_err        = len_err_q;
    assign o_frame_count    = frame_count_q;

endmodule

// File: tb/tb_task_answer_framer.sv
// Directed and randomized frames for task_answer_framer, checked against a byte-list model of the frame format.
module tb_task_answer_framer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_tanswer_ready = 1'b0;
    logic [7:0]  i_tdata = 8'h00;
    logic        i_tanswer_data_last = 1'b0;
    logic [11:0] i_packet_size_in_bytes = 12'd0;
    logic        o_tmanager_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_len_err;
    logic [15:0] o_frame_count;

    task_answer_framer dut (
        .i_clk                  (i_clk),
        .i_rst_n                (i_rst_n),
        .i_tanswer_ready        (i_tanswer_ready),
        .i_tdata                (i_tdata),
        .i_tanswer_data_last    (i_tanswer_data_last),
        .i_packet_size_in_bytes (i_packet_size_in_bytes),
        .o_tmanager_ready       (o_tmanager_ready),
        .o_tx_data              (o_tx_data),
        .o_tx_valid             (o_tx_valid),
        .i_tx_ready             (i_tx_ready),
        .o_busy                 (o_busy),
        .o_frame_done           (o_frame_done),
        .o_len_err              (o_len_err),
        .o_frame_count          (o_frame_count)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          failures = 0;
    int          exp_count = 0;
    logic [7:0]  src[$];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_valid"}, 32'(o_tx_valid), 32'd0);
        check({tag, " tx_data"}, 32'(o_tx_data), 32'd0);
        check({tag, " mgr_ready"}, 32'(o_tmanager_ready), 32'd0);
        check({tag, " busy"}, 32'(o_busy), 32'd0);
        check({tag, " frame_done"}, 32'(o_frame_done), 32'd0);
        check({tag, " len_err"}, 32'(o_len_err), 32'd0);
        check({tag, " frame_count"}, 32'(o_frame_count), 32'd0);
    endtask

    // mode 0: both sides always ready; 1: tx_ready toggles; 2: both sides stall randomly.
    // abort_at >= 0 returns as soon as that many payload bytes have been accepted.
    task automatic run_frame(input string name, input int size, input int mode, input int abort_at);
        int          nbytes = src.size();
        int          src_idx = 0;
        int          cyc = 0;
        int          budget = 8 * (nbytes + size) + 200;
        int          npay;
        bit          up_v = 1'b0;
        bit          pend = 1'b0;
        bit          done = 1'b0;
        bit          exp_err;
        logic [7:0]  pend_d = 8'h00;
        logic [7:0]  sum = 8'h00;
        logic [7:0]  tot = 8'h00;
        got_q.delete();
        i_packet_size_in_bytes = 12'(size);
        while (!done && cyc < budget) begin
            @(posedge i_clk);
            #1;
            if (!up_v && src_idx < nbytes && (mode != 2 || $urandom_range(0, 3) != 0)) up_v = 1'b1;
            i_tanswer_ready     = up_v;
            i_tdata             = up_v ? src[src_idx] : 8'h00;
            i_tanswer_data_last = up_v && (src_idx == nbytes - 1);
            case (mode)
                0:       i_tx_ready = 1'b1;
                1:       i_tx_ready = (cyc % 2 == 0);
                default: i_tx_ready = 1'($urandom_range(0, 1));
            endcase
            #3;
            if (pend) begin
                check({name, " held valid"}, 32'(o_tx_valid), 32'd1);
                check({name, " held data"}, 32'(o_tx_data), 32'(pend_d));
            end
            if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
            pend   = o_tx_valid && !i_tx_ready;
            pend_d = o_tx_data;
            if (i_tanswer_ready && o_tmanager_ready) begin
                src_idx++;
                up_v = 1'b0;
            end
            if (o_frame_done) done = 1'b1;
            cyc++;
            if (abort_at >= 0 && src_idx >= abort_at) return;
        end
        i_tanswer_ready     = 1'b0;
        i_tanswer_data_last = 1'b0;
        i_tx_ready          = 1'b0;
        check({name, " frame_done seen"}, 32'(done), 32'd1);

        // Reference frame built straight from the format rules.
        npay    = (nbytes < size) ? nbytes : size;
        exp_err = (nbytes != size) || (size == 0);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'd9);
        exp_q.push_back(8'(size >> 8));
        exp_q.push_back(8'(size & 255));
        for (int i = 0; i < npay; i++) exp_q.push_back(src[i]);
        for (int i = 1; i < exp_q.size(); i++) sum = sum + exp_q[i];
        exp_q.push_back(8'h00 - sum);
        exp_count = (exp_count + 1) % 65536;

        check({name, " byte count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        for (int i = 1; i < got_q.size(); i++) tot = tot + got_q[i];
        check({name, " cksum zero"}, 32'(tot), 32'd0);
        check({name, " src consumed"}, 32'(src_idx), 32'(nbytes));
        check({name, " frame_count"}, 32'(o_frame_count), 32'(exp_count));
        check({name, " len_err"}, 32'(o_len_err), 32'(exp_err));
        check({name, " busy after"}, 32'(o_busy), 32'd0);
        @(posedge i_clk);
        #4;
        check({name, " done pulse 1cyc"}, 32'(o_frame_done), 32'd0);
        $display("frame %s size=%0d bytes_in=%0d tx_bytes=%0d len_err=%0d count=%0d",
                 name, size, nbytes, got_q.size(), o_len_err, o_frame_count);
    endtask

    task automatic fill_random(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int size;
        int nb;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame("basic", 4, 0, -1);
        run_frame("toggle_ready", 4, 1, -1);

        src = '{8'h01, 8'h02};
        run_frame("short", 4, 0, -1);
        fill_random(6);
        run_frame("good_after_err", 6, 2, -1);

        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame("long_drain", 2, 0, -1);

        fill_random(4095);
        run_frame("max_len", 4095, 2, -1);

        for (int k = 0; k < 6; k++) begin
            size = $urandom_range(1, 40);
            case ($urandom_range(0, 2))
                0:       nb = size;
                1:       nb = $urandom_range(1, size);
                default: nb = size + $urandom_range(1, 5);
            endcase
            fill_random(nb);
            run_frame($sformatf("rand%0d", k), size, $urandom_range(0, 2), -1);
        end

        fill_random(8);
        run_frame("abort", 8, 0, 3);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        i_tanswer_ready     = 1'b0;
        i_tanswer_data_last = 1'b0;
        i_tx_ready          = 1'b0;
        exp_count           = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        fill_random(5);
        run_frame("after_reset", 5, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
